// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_if : decode/EX hazard-control bus (pipeline <-> controller)
// Rev 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32,
  parameter int SEL_W = 2
);
  logic             de_valid;
  logic [REG_W-1:0] de_rs1;
  logic [REG_W-1:0] de_rs2;
  logic             de_rs1_used;
  logic             de_rs2_used;
  logic [REG_W-1:0] de_rd;
  logic             de_rd_wr;
  logic             de_is_load;
  logic             de_is_mc;
  logic             ex_redirect;
  logic             mc_done;
  logic             stall_fd;
  logic             flush_de;
  logic             freeze;
  logic [SEL_W-1:0] fwd_a_sel;
  logic [SEL_W-1:0] fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd, de_rd_wr,
           de_is_load, de_is_mc, ex_redirect, mc_done,
    input  stall_fd, flush_de, freeze, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd, de_rd_wr,
           de_is_load, de_is_mc, ex_redirect, mc_done,
    output stall_fd, flush_de, freeze, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : shadow-pipeline hazard, forwarding and flush controller
// Rev 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 3,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(DEPTH)
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic             load;
    logic             mc;
    logic             rs1_used;
    logic             rs2_used;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } entry_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  entry_t           r_sh [1:DEPTH];
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  entry_t           w_de;
  logic             w_load_use;
  logic             w_freeze;
  logic             w_flush;
  logic             w_stall;
  logic [SEL_W-1:0] w_fwd_a;
  logic [SEL_W-1:0] w_fwd_b;

  // rd = x0 is never a producer
  function automatic logic produces(entry_t e, logic [REG_W-1:0] r);
    return e.valid && e.wr && (e.rd != '0) && (e.rd == r);
  endfunction

  assign w_de = '{valid: bus.de_valid, wr: bus.de_rd_wr, load: bus.de_is_load,
                  mc: bus.de_is_mc, rs1_used: bus.de_rs1_used,
                  rs2_used: bus.de_rs2_used, rd: bus.de_rd,
                  rs1: bus.de_rs1, rs2: bus.de_rs2};

  always_comb begin
    w_load_use = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if ((k + 1 < LOAD_READY) && r_sh[k].load &&
          ((bus.de_rs1_used && produces(r_sh[k], bus.de_rs1)) ||
           (bus.de_rs2_used && produces(r_sh[k], bus.de_rs2))))
        w_load_use = 1'b1;
    end
    w_load_use = w_load_use & bus.de_valid;
  end

  // Scan oldest to youngest so the youngest match wins
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int k = DEPTH; k >= 2; k--) begin
      if (r_sh[1].valid && r_sh[1].rs1_used && produces(r_sh[k], r_sh[1].rs1))
        w_fwd_a = SEL_W'(k - 1);
      if (r_sh[1].valid && r_sh[1].rs2_used && produces(r_sh[k], r_sh[1].rs2))
        w_fwd_b = SEL_W'(k - 1);
    end
  end

  assign w_freeze = (r_state == ST_BUSY);
  assign w_flush  = rst_n & bus.ex_redirect & ~w_freeze;
  assign w_stall  = rst_n & w_load_use & ~bus.ex_redirect & ~w_freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) r_sh[k] <= '0;
    end else if (!w_freeze) begin
      for (int k = DEPTH; k >= 2; k--) r_sh[k] <= r_sh[k-1];
      r_sh[1] <= (bus.de_valid && !w_stall && !w_flush) ? w_de : '0;
    end
  end

  // Busy starts one edge after the op reaches EX, so it freezes one stage later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (r_sh[1].valid && r_sh[1].mc) r_state <= ST_BUSY;
        ST_BUSY: if (bus.mc_done) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_stall || w_freeze) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall_fd  = w_stall;
  assign bus.flush_de  = w_flush;
  assign bus.freeze    = w_freeze;
  assign bus.fwd_a_sel = w_fwd_a;
  assign bus.fwd_b_sel = w_fwd_b;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : directed + random stimulus against a behavioural model
// Rev 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
  localparam int DEPTH      = 3;
  localparam int LOAD_READY = 3;
  localparam int REG_W      = 5;
  localparam int CNT_W      = 32;
  localparam int SEL_W      = $clog2(DEPTH);
  localparam int SCNT_W     = 3;

  typedef struct packed {
    logic v, wr, ld, mc, u1, u2;
    logic [REG_W-1:0] rd, rs1, rs2;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ins_t cur;
  logic redir, done;

  pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W),  .SEL_W(SEL_W)) bus ();
  pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(SCNT_W), .SEL_W(SEL_W)) sbus ();

  assign bus.de_valid    = cur.v;   assign sbus.de_valid    = cur.v;
  assign bus.de_rs1      = cur.rs1; assign sbus.de_rs1      = cur.rs1;
  assign bus.de_rs2      = cur.rs2; assign sbus.de_rs2      = cur.rs2;
  assign bus.de_rs1_used = cur.u1;  assign sbus.de_rs1_used = cur.u1;
  assign bus.de_rs2_used = cur.u2;  assign sbus.de_rs2_used = cur.u2;
  assign bus.de_rd       = cur.rd;  assign sbus.de_rd       = cur.rd;
  assign bus.de_rd_wr    = cur.wr;  assign sbus.de_rd_wr    = cur.wr;
  assign bus.de_is_load  = cur.ld;  assign sbus.de_is_load  = cur.ld;
  assign bus.de_is_mc    = cur.mc;  assign sbus.de_is_mc    = cur.mc;
  assign bus.ex_redirect = redir;   assign sbus.ex_redirect = redir;
  assign bus.mc_done     = done;    assign sbus.mc_done     = done;

  pipe_hazard_ctrl #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .REG_W(REG_W),
                     .CNT_W(CNT_W), .SEL_W(SEL_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  // Narrow-counter copy exercises saturation
  pipe_hazard_ctrl #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .REG_W(REG_W),
                     .CNT_W(SCNT_W), .SEL_W(SEL_W))
    dut_sat (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));

  // Reference model: instructions in flight per stage, busy flag, plain counts
  ins_t   st [1:DEPTH];
  bit     m_busy;
  longint m_stall, m_flush;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat(longint v, int w);
    longint m = (longint'(1) <<< w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic bit writes(ins_t p, logic [REG_W-1:0] r);
    return p.v && p.wr && (p.rd != 0) && (p.rd == r);
  endfunction

  // A load at stage k reaches stage k+1 when the consumer reaches EX
  function automatic bit m_load_use();
    if (!cur.v) return 0;
    for (int k = 1; k < DEPTH; k++)
      if (st[k].ld && (k + 1 < LOAD_READY) &&
          ((cur.u1 && writes(st[k], cur.rs1)) || (cur.u2 && writes(st[k], cur.rs2))))
        return 1;
    return 0;
  endfunction

  function automatic int m_fwd(bit used, logic [REG_W-1:0] r);
    if (!st[1].v || !used) return 0;
    for (int k = 2; k <= DEPTH; k++)
      if (writes(st[k], r)) return k - 1;
    return 0;
  endfunction

  function automatic ins_t mk(int rd, int rs1, int rs2, bit u1, bit u2, bit wr, bit ld, bit mc);
    ins_t i;
    i.v = 1'b1; i.wr = wr; i.ld = ld; i.mc = mc; i.u1 = u1; i.u2 = u2;
    i.rd = REG_W'(rd); i.rs1 = REG_W'(rs1); i.rs2 = REG_W'(rs2);
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.v   = ($urandom_range(0, 7) != 0);
    i.wr  = ($urandom_range(0, 3) != 0);
    i.ld  = ($urandom_range(0, 2) == 0);
    i.mc  = ($urandom_range(0, 15) == 0);
    i.u1  = 1'($urandom_range(0, 1));
    i.u2  = 1'($urandom_range(0, 1));
    i.rd  = REG_W'($urandom_range(0, 3));
    i.rs1 = REG_W'($urandom_range(0, 3));
    i.rs2 = REG_W'($urandom_range(0, 3));
    return i;
  endfunction

  // One clock: entered at posedge+1, leaves at the next posedge+1
  task automatic cycle(ins_t i, logic r, logic d, output bit taken);
    bit es, ef, nb;
    cur = i; redir = r; done = d;
    #1;
    ef = r && !m_busy;
    es = m_load_use() && !r && !m_busy;
    chk("stall_fd",  bus.stall_fd,  es);
    chk("flush_de",  bus.flush_de,  ef);
    chk("freeze",    bus.freeze,    m_busy);
    chk("fwd_a_sel", bus.fwd_a_sel, m_fwd(st[1].u1, st[1].rs1));
    chk("fwd_b_sel", bus.fwd_b_sel, m_fwd(st[1].u2, st[1].rs2));
    chk("stall_cnt", bus.stall_cnt, sat(m_stall, CNT_W));
    chk("flush_cnt", bus.flush_cnt, sat(m_flush, CNT_W));
    chk("stall_cnt_sat", sbus.stall_cnt, sat(m_stall, SCNT_W));
    chk("flush_cnt_sat", sbus.flush_cnt, sat(m_flush, SCNT_W));
    taken = !m_busy && !es;
    m_stall += (es || m_busy) ? 1 : 0;
    m_flush += ef ? 1 : 0;
    nb = m_busy ? !d : (st[1].v && st[1].mc);
    if (!m_busy) begin
      for (int k = DEPTH; k >= 2; k--) st[k] = st[k-1];
      st[1] = (i.v && !es && !ef) ? i : '0;
    end
    m_busy = nb;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(ins_t i, logic r = 1'b0);
    bit taken = 0;
    for (int n = 0; n < 20 && !taken; n++) cycle(i, r, 1'b0, taken);
    if (!taken) chk("issue_timeout", 0, 1);
  endtask

  task automatic idle(int n);
    bit t;
    for (int j = 0; j < n; j++) cycle('0, 1'b0, 1'b0, t);
  endtask

  // Asserted between edges: outputs must clear with no clock edge in between
  task automatic do_reset();
    redir = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_stall_fd",  bus.stall_fd,  0);
    chk("rst_flush_de",  bus.flush_de,  0);
    chk("rst_freeze",    bus.freeze,    0);
    chk("rst_fwd_a",     bus.fwd_a_sel, 0);
    chk("rst_fwd_b",     bus.fwd_b_sel, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_flush_cnt", bus.flush_cnt, 0);
    for (int k = 1; k <= DEPTH; k++) st[k] = '0;
    m_busy = 0; m_stall = 0; m_flush = 0;
    #3;
    redir = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ins_t pend, mul, dep;
    bit   t, need;
    logic r, d;
    cur = '0; redir = 1'b0; done = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back and distance-2 dependences
    issue(mk(5, 1, 2, 1, 1, 1, 0, 0));
    issue(mk(6, 5, 1, 1, 1, 1, 0, 0));
    idle(3);
    issue(mk(5, 1, 2, 1, 1, 1, 0, 0));
    issue(mk(9, 3, 4, 1, 1, 1, 0, 0));
    issue(mk(6, 5, 1, 1, 1, 1, 0, 0));
    idle(3);
    // Load-use
    issue(mk(7, 2, 0, 1, 0, 1, 1, 0));
    issue(mk(8, 7, 7, 1, 1, 1, 0, 0));
    idle(3);
    // x0 producers never forward or stall
    issue(mk(0, 1, 0, 1, 0, 1, 1, 0));
    issue(mk(10, 0, 0, 1, 1, 1, 0, 0));
    idle(3);
    // Redirect coincident with load-use
    issue(mk(11, 2, 0, 1, 0, 1, 1, 0));
    issue(mk(12, 11, 0, 1, 0, 1, 0, 0), 1'b1);
    idle(3);
    // Spurious mc_done while idle
    cycle('0, 1'b0, 1'b1, t);
    idle(2);
    // Multi-cycle op with completion five cycles into the freeze
    mul = mk(13, 1, 2, 1, 1, 1, 0, 1);
    dep = mk(14, 13, 13, 1, 1, 1, 0, 0);
    issue(mul);
    cycle('0, 1'b0, 1'b0, t);
    for (int j = 0; j < 4; j++) cycle(dep, 1'b0, 1'b0, t);
    cycle(dep, 1'b0, 1'b1, t);
    issue(dep);
    idle(3);
    // Reset in the middle of a freeze
    issue(mul);
    cycle('0, 1'b0, 1'b0, t);
    cycle(dep, 1'b0, 1'b0, t);
    cycle(dep, 1'b0, 1'b0, t);
    do_reset();
    idle(2);

    need = 1;
    for (int n = 0; n < 4000; n++) begin
      if (need) pend = rand_ins();
      r = ($urandom_range(0, 7) == 0);
      d = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      cycle(pend, r, d, t);
      need = t;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
